// File: rtl/defs_pkg.sv
// Shared types and encodings for the multicycle CPU control path.
// State, opcode, ALU, flag and control-word definitions used by control_unit and its bench.
package defs_pkg;

    typedef enum logic [3:0] {
        OP_LI   = 4'd0,
        OP_ADDI = 4'd1,
        OP_LW   = 4'd2,
        OP_SW   = 4'd3,
        OP_ADD  = 4'd4,
        OP_SUB  = 4'd5,
        OP_AND  = 4'd6,
        OP_OR   = 4'd7,
        OP_XOR  = 4'd8,
        OP_SLL  = 4'd9,
        OP_SRL  = 4'd10,
        OP_SRA  = 4'd11,
        OP_LINK = 4'd12,
        OP_JMP  = 4'd13,
        OP_JPR  = 4'd14,
        OP_BRH  = 4'd15
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7
    } alu_opcode_t;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        WB_LI,
        EXEC_ADDI,
        WB_ADDI,
        EXEC_ALU,
        WB_ALU,
        EXEC_LW,
        MEM_LW,
        WB_LW,
        EXEC_SW,
        MEM_SW,
        EXEC_LINK,
        EXEC_JMP,
        EXEC_JPR,
        EXEC_BRH
    } state_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
    } alu_flags_t;

    typedef struct packed {
        logic        ROM_read;
        logic        IR_load;
        logic        PC_write;
        logic        PC_sel;
        logic [1:0]  ADDER_sel;
        logic        AB_load;
        logic        RF_write;
        logic [1:0]  REGW_sel;
        logic        ACC_load;
        logic        FLAG_load;
        logic        ALU_sel;
        alu_opcode_t ALU_op;
        logic        MAR_load;
        logic        MEM_read;
        logic        MDR_load;
        logic        MEM_write;
        logic        REG2_sel;
    } ctrl_sig_t;

    // Branch condition codes (IR[11:9])
    localparam logic [2:0] COND_Z  = 3'b000;
    localparam logic [2:0] COND_NZ = 3'b001;
    localparam logic [2:0] COND_LT = 3'b010;
    localparam logic [2:0] COND_GE = 3'b011;
    localparam logic [2:0] COND_C  = 3'b100;
    localparam logic [2:0] COND_NC = 3'b101;
    localparam logic [2:0] COND_N  = 3'b110;
    localparam logic [2:0] COND_AL = 3'b111;

    localparam logic [1:0] REGW_ACC = 2'd0;
    localparam logic [1:0] REGW_IMM = 2'd1;
    localparam logic [1:0] REGW_MDR = 2'd2;
    localparam logic [1:0] REGW_PC  = 2'd3;

    localparam logic [1:0] ADDER_PC_INC  = 2'd0;
    localparam logic [1:0] ADDER_PC_IMM  = 2'd1;
    localparam logic [1:0] ADDER_REG_IMM = 2'd2;

endpackage

// File: rtl/cond_eval.sv
// Branch-condition evaluator: decides whether BRH is taken from cond and the registered ALU flags.
module cond_eval
    import defs_pkg::*;
(
    input  logic [2:0] cond,
    input  alu_flags_t flags,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_Z:  taken = flags.zero;
            COND_NZ: taken = ~flags.zero;
            COND_LT: taken = flags.neg ^ flags.ovf;
            COND_GE: taken = ~(flags.neg ^ flags.ovf);
            COND_C:  taken = flags.carry;
            COND_NC: taken = ~flags.carry;
            COND_N:  taken = flags.neg;
            COND_AL: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback and
// produces the datapath control word, a retire pulse and a retired-instruction count.
module control_unit
    import defs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  opcode_t     opcode,
    input  logic [2:0]  cond,
    input  alu_flags_t  flags,
    input  logic        mem_ready,
    output ctrl_sig_t   ctrl,
    output state_t      state,
    output logic        retire,
    output logic [15:0] icount
);

    state_t next_state;
    logic   taken;

    cond_eval u_cond_eval (
        .cond  (cond),
        .flags (flags),
        .taken (taken)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FETCH;
            icount <= '0;
        end else if (en) begin
            state <= next_state;
            if (retire) begin
                icount <= icount + 16'd1;
            end
        end
    end

    always_comb begin
        next_state = state;
        ctrl       = '0;

        case (state)
            FETCH: begin
                ctrl.ROM_read  = 1'b1;
                ctrl.IR_load   = 1'b1;
                ctrl.PC_write  = 1'b1;
                ctrl.PC_sel    = 1'b0;
                ctrl.ADDER_sel = ADDER_PC_INC;
                next_state     = DECODE;
            end
            DECODE: begin
                ctrl.AB_load = 1'b1;
                case (opcode)
                    OP_LI:   next_state = WB_LI;
                    OP_ADDI: next_state = EXEC_ADDI;
                    OP_LW:   next_state = EXEC_LW;
                    OP_SW:   next_state = EXEC_SW;
                    OP_LINK: next_state = EXEC_LINK;
                    OP_JMP:  next_state = EXEC_JMP;
                    OP_JPR:  next_state = EXEC_JPR;
                    OP_BRH:  next_state = EXEC_BRH;
                    default: next_state = EXEC_ALU;
                endcase
            end
            WB_LI: begin
                ctrl.RF_write = 1'b1;
                ctrl.REGW_sel = REGW_IMM;
                next_state    = FETCH;
            end
            EXEC_ADDI: begin
                ctrl.ACC_load  = 1'b1;
                ctrl.FLAG_load = 1'b1;
                ctrl.ALU_sel   = 1'b1;
                ctrl.ALU_op    = ALU_ADD;
                next_state     = WB_ADDI;
            end
            WB_ADDI, WB_ALU: begin
                ctrl.RF_write = 1'b1;
                ctrl.REGW_sel = REGW_ACC;
                next_state    = FETCH;
            end
            EXEC_ALU: begin
                ctrl.ACC_load  = 1'b1;
                ctrl.FLAG_load = 1'b1;
                ctrl.ALU_sel   = 1'b0;
                // ADD..SRA are contiguous, so the ALU op is the offset from ADD
                ctrl.ALU_op    = alu_opcode_t'({1'b0, 3'(opcode - OP_ADD)});
                next_state     = WB_ALU;
            end
            EXEC_LW, EXEC_SW: begin
                ctrl.MAR_load  = 1'b1;
                ctrl.ADDER_sel = ADDER_REG_IMM;
                next_state     = (state == EXEC_LW) ? MEM_LW : MEM_SW;
            end
            MEM_LW: begin
                ctrl.MEM_read = 1'b1;
                ctrl.MDR_load = 1'b1;
                if (mem_ready) begin
                    next_state = WB_LW;
                end
            end
            WB_LW: begin
                ctrl.RF_write = 1'b1;
                ctrl.REGW_sel = REGW_MDR;
                next_state    = FETCH;
            end
            MEM_SW: begin
                ctrl.MEM_write = 1'b1;
                ctrl.REG2_sel  = 1'b1;
                if (mem_ready) begin
                    next_state = FETCH;
                end
            end
            EXEC_LINK: begin
                ctrl.RF_write = 1'b1;
                ctrl.REGW_sel = REGW_PC;
                next_state    = FETCH;
            end
            EXEC_JMP, EXEC_JPR, EXEC_BRH: begin
                ctrl.PC_sel    = 1'b1;
                ctrl.ADDER_sel = (state == EXEC_JPR) ? ADDER_REG_IMM : ADDER_PC_IMM;
                ctrl.PC_write  = (state == EXEC_BRH) ? taken : 1'b1;
                next_state     = FETCH;
            end
            default: next_state = FETCH;
        endcase

        retire = en && (next_state == FETCH);

        if (!en) begin
            ctrl.ROM_read  = 1'b0;
            ctrl.IR_load   = 1'b0;
            ctrl.PC_write  = 1'b0;
            ctrl.AB_load   = 1'b0;
            ctrl.RF_write  = 1'b0;
            ctrl.ACC_load  = 1'b0;
            ctrl.FLAG_load = 1'b0;
            ctrl.MAR_load  = 1'b0;
            ctrl.MEM_read  = 1'b0;
            ctrl.MDR_load  = 1'b0;
            ctrl.MEM_write = 1'b0;
        end

        // The state register already reads FETCH under reset, so the word must be forced quiet here
        if (rst) begin
            ctrl   = '0;
            retire = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction path model compared every cycle,
// directed scenarios with literal expectations, randomized traffic and the icount wrap.
module tb_control_unit;
    import defs_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b1;
    logic        mem_ready = 1'b0;
    opcode_t     opcode = OP_LI;
    logic [2:0]  cond = 3'd0;
    alu_flags_t  flags = '0;
    ctrl_sig_t   ctrl;
    state_t      state;
    logic        retire;
    logic [15:0] icount;

    int unsigned errors = 0;
    int unsigned checks = 0;

    int          m_idx = 0;
    logic [15:0] m_count = '0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .opcode    (opcode),
        .cond      (cond),
        .flags     (flags),
        .mem_ready (mem_ready),
        .ctrl      (ctrl),
        .state     (state),
        .retire    (retire),
        .icount    (icount)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, want);
        end
    endtask

    function automatic int path_len(opcode_t op);
        case (op)
            OP_LI, OP_LINK, OP_JMP, OP_JPR, OP_BRH: return 3;
            OP_LW:                                  return 5;
            default:                                return 4;
        endcase
    endfunction

    function automatic state_t path_at(opcode_t op, int i);
        state_t seq [5];
        seq[0] = FETCH;
        seq[1] = DECODE;
        seq[2] = FETCH;
        seq[3] = FETCH;
        seq[4] = FETCH;
        case (op)
            OP_LI:   seq[2] = WB_LI;
            OP_ADDI: begin seq[2] = EXEC_ADDI; seq[3] = WB_ADDI; end
            OP_LW:   begin seq[2] = EXEC_LW; seq[3] = MEM_LW; seq[4] = WB_LW; end
            OP_SW:   begin seq[2] = EXEC_SW; seq[3] = MEM_SW; end
            OP_LINK: seq[2] = EXEC_LINK;
            OP_JMP:  seq[2] = EXEC_JMP;
            OP_JPR:  seq[2] = EXEC_JPR;
            OP_BRH:  seq[2] = EXEC_BRH;
            default: begin seq[2] = EXEC_ALU; seq[3] = WB_ALU; end
        endcase
        return seq[i];
    endfunction

    function automatic logic branch_taken(logic [2:0] c, alu_flags_t f);
        logic [7:0] t;
        t = {1'b1, f.neg, ~f.carry, f.carry, ~(f.neg ^ f.ovf), f.neg ^ f.ovf, ~f.zero, f.zero};
        return t[c];
    endfunction

    function automatic ctrl_sig_t spec_ctrl(state_t s, opcode_t op, logic [2:0] c, alu_flags_t f);
        ctrl_sig_t w;
        w = '0;
        case (s)
            FETCH:     begin w.ROM_read = 1; w.IR_load = 1; w.PC_write = 1; end
            DECODE:    w.AB_load = 1;
            WB_LI:     begin w.RF_write = 1; w.REGW_sel = 2'd1; end
            EXEC_ADDI: begin w.ACC_load = 1; w.FLAG_load = 1; w.ALU_sel = 1; w.ALU_op = ALU_ADD; end
            WB_ADDI:   w.RF_write = 1;
            EXEC_ALU:  begin
                w.ACC_load = 1; w.FLAG_load = 1;
                w.ALU_op = alu_opcode_t'(4'(int'(op) - 4));
            end
            WB_ALU:    w.RF_write = 1;
            EXEC_LW:   begin w.MAR_load = 1; w.ADDER_sel = 2'd2; end
            EXEC_SW:   begin w.MAR_load = 1; w.ADDER_sel = 2'd2; end
            MEM_LW:    begin w.MEM_read = 1; w.MDR_load = 1; end
            WB_LW:     begin w.RF_write = 1; w.REGW_sel = 2'd2; end
            MEM_SW:    begin w.MEM_write = 1; w.REG2_sel = 1; end
            EXEC_LINK: begin w.RF_write = 1; w.REGW_sel = 2'd3; end
            EXEC_JMP:  begin w.PC_write = 1; w.PC_sel = 1; w.ADDER_sel = 2'd1; end
            EXEC_JPR:  begin w.PC_write = 1; w.PC_sel = 1; w.ADDER_sel = 2'd2; end
            EXEC_BRH:  begin w.PC_write = branch_taken(c, f); w.PC_sel = 1; w.ADDER_sel = 2'd1; end
            default:   w = '0;
        endcase
        return w;
    endfunction

    // Reference model: position within the current instruction's state path
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_idx   = 0;
            m_count = '0;
        end else if (en) begin
            if (!((path_at(opcode, m_idx) == MEM_LW || path_at(opcode, m_idx) == MEM_SW) && !mem_ready)) begin
                m_idx = m_idx + 1;
                if (m_idx >= path_len(opcode)) begin
                    m_idx   = 0;
                    m_count = m_count + 16'd1;
                end
            end
        end
    end

    initial forever begin
        state_t    st;
        ctrl_sig_t w;
        logic      r;
        @(negedge clk);
        st = path_at(opcode, m_idx);
        w  = spec_ctrl(st, opcode, cond, flags);
        r  = (m_idx == path_len(opcode) - 1) && !((st == MEM_LW || st == MEM_SW) && !mem_ready);
        if (!en) begin
            r = 1'b0;
            w.ROM_read = 0; w.IR_load = 0; w.PC_write = 0; w.AB_load = 0;
            w.RF_write = 0; w.ACC_load = 0; w.FLAG_load = 0; w.MAR_load = 0;
            w.MEM_read = 0; w.MDR_load = 0; w.MEM_write = 0;
        end
        if (rst) begin
            w  = '0;
            r  = 1'b0;
            st = FETCH;
        end
        check("m_state",  32'(state),  32'(st));
        check("m_ctrl",   32'(ctrl),   32'(w));
        check("m_retire", 32'(retire), 32'(r));
        check("m_icount", 32'(icount), 32'(m_count));
    end

    initial begin
        int rc;
        int acc;

        // Reset state
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_state",  32'(state),  32'(FETCH));
        check("rst_icount", 32'(icount), 32'd0);
        check("rst_ctrl",   32'(ctrl),   32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("fetch_state",    32'(state),         32'(FETCH));
        check("fetch_rom_read", 32'(ctrl.ROM_read), 32'd1);

        // ADD: FETCH, DECODE, EXEC_ALU, WB_ALU
        opcode = OP_ADD;
        rc = 0;
        @(negedge clk);
        check("add_decode", 32'(state), 32'(DECODE)); rc += int'(retire);
        @(negedge clk);
        check("add_exec", 32'(state), 32'(EXEC_ALU));
        check("add_aluop", 32'(ctrl.ALU_op), 32'h0); rc += int'(retire);
        @(negedge clk);
        check("add_wb", 32'(state), 32'(WB_ALU));
        check("add_rfw", 32'(ctrl.RF_write), 32'd1); rc += int'(retire);
        @(negedge clk);
        rc += int'(retire);
        check("add_fetch", 32'(state), 32'(FETCH));
        check("add_icount", 32'(icount), 32'd1);
        check("add_retires", 32'(rc), 32'd1);

        // LW with mem_ready low for 3 cycles
        #1 opcode = OP_LW; mem_ready = 1'b0;
        @(negedge clk); check("lw_decode", 32'(state), 32'(DECODE));
        @(negedge clk); check("lw_exec", 32'(state), 32'(EXEC_LW));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("lw_mem_state", 32'(state), 32'(MEM_LW));
            check("lw_mem_read", 32'(ctrl.MEM_read), 32'd1);
            if (k == 3) begin
                #1 mem_ready = 1'b1;
            end
        end
        @(negedge clk);
        check("lw_wb", 32'(state), 32'(WB_LW));
        check("lw_regw", 32'(ctrl.REGW_sel), 32'd2);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        check("lw_icount", 32'(icount), 32'd2);

        // BRH cond=Z, not taken then taken
        #1 opcode = OP_BRH; cond = 3'b000; flags = '0;
        @(negedge clk);
        @(negedge clk);
        check("brh_nt_state", 32'(state), 32'(EXEC_BRH));
        check("brh_nt_pcw", 32'(ctrl.PC_write), 32'd0);
        @(negedge clk);
        #1 flags.zero = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("brh_t_state", 32'(state), 32'(EXEC_BRH));
        check("brh_t_pcw", 32'(ctrl.PC_write), 32'd1);
        check("brh_t_pcsel", 32'(ctrl.PC_sel), 32'd1);
        @(negedge clk);
        check("brh_icount", 32'(icount), 32'd4);

        // ADDI with en dropped for 2 cycles in EXEC_ADDI
        #1 opcode = OP_ADDI; flags = '0;
        acc = 0;
        @(negedge clk);
        check("addi_decode", 32'(state), 32'(DECODE));
        @(posedge clk); #1 en = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("addi_hold_state", 32'(state), 32'(EXEC_ADDI));
            check("addi_hold_acc", 32'(ctrl.ACC_load), 32'd0);
            acc += int'(ctrl.ACC_load);
        end
        @(posedge clk); #1 en = 1'b1;
        @(negedge clk);
        check("addi_resume_state", 32'(state), 32'(EXEC_ADDI));
        acc += int'(ctrl.ACC_load);
        @(negedge clk);
        check("addi_wb", 32'(state), 32'(WB_ADDI));
        acc += int'(ctrl.ACC_load);
        check("addi_acc_count", 32'(acc), 32'd1);
        @(negedge clk);
        check("addi_icount", 32'(icount), 32'd5);

        // Async reset in the middle of MEM_SW
        #1 opcode = OP_SW; mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("sw_mem_state", 32'(state), 32'(MEM_SW));
        check("sw_mem_write", 32'(ctrl.MEM_write), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1; mem_ready = 1'b1;
        #1;
        check("swrst_ctrl", 32'(ctrl), 32'd0);
        check("swrst_state", 32'(state), 32'(FETCH));
        check("swrst_icount", 32'(icount), 32'd0);
        check("swrst_retire", 32'(retire), 32'd0);
        @(negedge clk);
        check("swrst_hold_retire", 32'(retire), 32'd0);
        #1 rst = 1'b0; mem_ready = 1'b0;
        #1;
        check("swrst_after_state", 32'(state), 32'(FETCH));
        check("swrst_after_icount", 32'(icount), 32'd0);

        // Randomized traffic; opcode changes only between instructions
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            #1;
            en        = ($urandom_range(0, 3) != 0);
            mem_ready = ($urandom_range(0, 2) == 0);
            cond      = 3'($urandom);
            flags     = alu_flags_t'(4'($urandom));
            if (m_idx == 0) begin
                opcode = opcode_t'(4'($urandom));
            end
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                #2 rst = 1'b0;
            end
        end

        // icount wrap via a long run of LI
        @(negedge clk);
        #1 rst = 1'b1; en = 1'b1; opcode = OP_LI; mem_ready = 1'b0;
        #1 rst = 1'b0;
        repeat (3 * 65535) @(negedge clk);
        check("wrap_icount_max", 32'(icount), 32'hFFFF);
        check("wrap_state_max", 32'(state), 32'(FETCH));
        repeat (3) @(negedge clk);
        check("wrap_icount_zero", 32'(icount), 32'h0000);
        check("wrap_state", 32'(state), 32'(FETCH));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
